// File: rtl/alu_dec_pkg.sv
// Shared decode types and the combinational RV32I-subset decoder for alu_decoder.
package alu_dec_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic [2:0]  alu_ctrl;
        logic        alu_src_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        branch_ne;
        logic        illegal;
    } dec_bundle_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_t;

    function automatic dec_bundle_t decode_insn(input logic [31:0] insn);
        dec_bundle_t b;
        logic        legal;
        logic [2:0]  f3;
        logic [6:0]  f7;
        b     = '0;
        legal = 1'b1;
        f3    = insn[14:12];
        f7    = insn[31:25];
        b.rs1 = insn[19:15];
        case (insn[6:0])
            OP_R: begin
                b.rs2       = insn[24:20];
                b.rd        = insn[11:7];
                b.reg_write = 1'b1;
                legal       = (f7 == 7'h00) || (f7 == 7'h20);
                case (f3)
                    3'b000:         b.alu_ctrl = f7[5] ? ALU_SUB : ALU_ADD;
                    3'b111:         b.alu_ctrl = ALU_AND;
                    3'b110:         b.alu_ctrl = ALU_OR;
                    3'b100:         b.alu_ctrl = ALU_XOR;
                    3'b010, 3'b011: b.alu_ctrl = ALU_SLT;
                    default:        legal      = 1'b0;
                endcase
            end
            OP_I: begin
                b.rd          = insn[11:7];
                b.imm         = {{20{insn[31]}}, insn[31:20]};
                b.alu_src_imm = 1'b1;
                b.reg_write   = 1'b1;
                case (f3)
                    3'b000:         b.alu_ctrl = ALU_ADD;
                    3'b111:         b.alu_ctrl = ALU_AND;
                    3'b110:         b.alu_ctrl = ALU_OR;
                    3'b100:         b.alu_ctrl = ALU_XOR;
                    3'b010, 3'b011: b.alu_ctrl = ALU_SLT;
                    default:        legal      = 1'b0;
                endcase
            end
            OP_LOAD: begin
                b.rd          = insn[11:7];
                b.imm         = {{20{insn[31]}}, insn[31:20]};
                b.alu_src_imm = 1'b1;
                b.mem_read    = 1'b1;
                b.reg_write   = 1'b1;
            end
            OP_STORE: begin
                b.rs2         = insn[24:20];
                b.imm         = {{20{insn[31]}}, insn[31:25], insn[11:7]};
                b.alu_src_imm = 1'b1;
                b.mem_write   = 1'b1;
            end
            OP_BRANCH: begin
                b.rs2       = insn[24:20];
                b.imm       = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
                b.alu_ctrl  = ALU_SUB;
                b.branch    = 1'b1;
                b.branch_ne = f3[0];
                legal       = (f3[2:1] == 2'b00);
            end
            default: legal = 1'b0;
        endcase
        // Illegal words collapse to a NOP so execute never sees stray side effects.
        if (!legal) begin
            b         = '0;
            b.illegal = 1'b1;
        end else begin
            b.illegal = 1'b0;
        end
        return b;
    endfunction

endpackage

// File: rtl/alu_dec_skid.sv
// Generic 2-entry skid buffer: registered in_ready, 1-cycle latency, bundle held under stall.
import alu_dec_pkg::*;

module alu_dec_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state_r;
    buf_state_t   state_nxt_s;
    logic [W-1:0] out_data_r;
    logic [W-1:0] skid_data_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         accept_s;
    logic         present_s;
    logic         load_out_s;
    logic         load_skid_s;
    logic         out_from_skid_s;

    assign accept_s  = in_valid && in_ready_r;
    assign present_s = out_valid_r && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BUF_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BUF_EMPTY: begin
                if (accept_s) state_nxt_s = BUF_ONE;
                else          state_nxt_s = BUF_EMPTY;
            end
            BUF_ONE: begin
                if (accept_s && !present_s)      state_nxt_s = BUF_FULL;
                else if (!accept_s && present_s) state_nxt_s = BUF_EMPTY;
                else                             state_nxt_s = BUF_ONE;
            end
            BUF_FULL: begin
                if (present_s) state_nxt_s = BUF_ONE;
                else           state_nxt_s = BUF_FULL;
            end
            default: state_nxt_s = BUF_EMPTY;
        endcase
    end

    // Data-path load selects
    always_comb begin
        load_out_s      = 1'b0;
        load_skid_s     = 1'b0;
        out_from_skid_s = 1'b0;
        case (state_r)
            BUF_EMPTY: load_out_s = accept_s;
            BUF_ONE: begin
                if (accept_s && present_s) load_out_s  = 1'b1;
                else if (accept_s)         load_skid_s = 1'b1;
                else                       load_out_s  = 1'b0;
            end
            BUF_FULL: begin
                if (present_s) begin
                    load_out_s      = 1'b1;
                    out_from_skid_s = 1'b1;
                end else begin
                    load_out_s      = 1'b0;
                end
            end
            default: load_out_s = 1'b0;
        endcase
    end

    // Output and skid data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            skid_data_r <= '0;
        end else begin
            if (load_out_s) out_data_r <= out_from_skid_s ? skid_data_r : in_data;
            if (load_skid_s) skid_data_r <= in_data;
        end
    end

    // Handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s != BUF_FULL);
            out_valid_r <= (state_nxt_s != BUF_EMPTY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: rtl/alu_decoder.sv
// RV32I decode stage for the ALU. Define ALU_DEC_ILLEGAL_EN to expose the illegal and
// illegal_seen outputs; otherwise illegal words silently decode to a NOP.
import alu_dec_pkg::*;

module alu_decoder #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      alu_ctrl,
    output logic            alu_src_imm,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            branch_ne
`ifdef ALU_DEC_ILLEGAL_EN
    ,
    output logic            illegal,
    output logic            illegal_seen
`endif
);

    localparam int BW = $bits(dec_bundle_t);

    dec_bundle_t dec_s;
    dec_bundle_t out_s;
    logic        out_valid_s;

    assign dec_s = decode_insn(in_insn);

    alu_dec_skid #(.W(BW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_s)
    );

    assign out_valid   = out_valid_s;
    assign alu_ctrl    = out_s.alu_ctrl;
    assign alu_src_imm = out_s.alu_src_imm;
    assign imm         = out_s.imm;
    assign rs1         = out_s.rs1;
    assign rs2         = out_s.rs2;
    assign rd          = out_s.rd;
    assign reg_write   = out_s.reg_write;
    assign mem_read    = out_s.mem_read;
    assign mem_write   = out_s.mem_write;
    assign branch      = out_s.branch;
    assign branch_ne   = out_s.branch_ne;

`ifdef ALU_DEC_ILLEGAL_EN
    logic illegal_seen_r;

    // Sticky flag: set once an illegal bundle has been handed to execute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen_r <= 1'b0;
        end else if (out_valid_s && out_ready && out_s.illegal) begin
            illegal_seen_r <= 1'b1;
        end else begin
            illegal_seen_r <= illegal_seen_r;
        end
    end

    assign illegal      = out_s.illegal;
    assign illegal_seen = illegal_seen_r;
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// Directed self-checking bench for alu_decoder (covers ALU_DEC_ILLEGAL_EN when defined).
module tb_alu_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_insn = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  alu_ctrl;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, mem_read, mem_write, branch, branch_ne;
`ifdef ALU_DEC_ILLEGAL_EN
    logic        illegal, illegal_seen;
`endif

    int tests = 0;
    int fails = 0;
    logic [55:0] got;

    always #5 clk = ~clk;

    alu_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn), .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .branch_ne(branch_ne)
`ifdef ALU_DEC_ILLEGAL_EN
        , .illegal(illegal), .illegal_seen(illegal_seen)
`endif
    );

    assign got = {alu_ctrl, alu_src_imm, imm, rs1, rs2, rd,
                  reg_write, mem_read, mem_write, branch, branch_ne};

    function automatic logic [55:0] mk(input logic [2:0] a, input logic s, input logic [31:0] i,
                                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                       input logic rw, input logic mr, input logic mw,
                                       input logic br, input logic bne);
        return {a, s, i, r1, r2, d, rw, mr, mw, br, bne};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] insn);
        in_insn   = insn;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (got !== 56'h0) begin fails++; $display("FAIL reset_bundle got %h exp 0", got); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL release_out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_rtype();
        logic [55:0] e;
        send(32'h002081B3); e = mk(3'b000, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b1 || got !== e) begin fails++; $display("FAIL add got v=%b %h exp %h", out_valid, got, e); end
        send(32'h407302B3); e = mk(3'b001, 1'b0, 32'h0, 5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b1 || got !== e) begin fails++; $display("FAIL sub got v=%b %h exp %h", out_valid, got, e); end
        send(32'h00C5E533); e = mk(3'b011, 1'b0, 32'h0, 5'd11, 5'd12, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (got !== e) begin fails++; $display("FAIL or got %h exp %h", got, e); end
        send(32'h009433B3); e = mk(3'b101, 1'b0, 32'h0, 5'd8, 5'd9, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (got !== e) begin fails++; $display("FAIL sltu got %h exp %h", got, e); end
        drain();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rtype_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_itype();
        logic [55:0] e;
        send(32'hFFF00093); e = mk(3'b000, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (got !== e) begin fails++; $display("FAIL addi got %h exp %h", got, e); end
        send(32'h0F017213); e = mk(3'b010, 1'b1, 32'h000000F0, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (got !== e) begin fails++; $display("FAIL andi got %h exp %h", got, e); end
        send(32'h0050A093); e = mk(3'b101, 1'b1, 32'h00000005, 5'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (got !== e) begin fails++; $display("FAIL slti got %h exp %h", got, e); end
        drain();
    endtask

    task automatic test_mem();
        logic [55:0] e;
        send(32'hFF812283); e = mk(3'b000, 1'b1, 32'hFFFFFFF8, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++; if (got !== e) begin fails++; $display("FAIL lw got %h exp %h", got, e); end
        send(32'h00612623); e = mk(3'b000, 1'b1, 32'h0000000C, 5'd2, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++; if (got !== e) begin fails++; $display("FAIL sw got %h exp %h", got, e); end
        drain();
    endtask

    task automatic test_branch();
        logic [55:0] e;
        send(32'hFE208EE3); e = mk(3'b001, 1'b0, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tests++; if (got !== e) begin fails++; $display("FAIL beq got %h exp %h", got, e); end
        send(32'h00419463); e = mk(3'b001, 1'b0, 32'h00000008, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tests++; if (got !== e) begin fails++; $display("FAIL bne got %h exp %h", got, e); end
        drain();
    endtask

    task automatic test_illegal();
        logic [55:0] e;
        send(32'h002081B3);
        send(32'hFFFFFFFF);
        tests++; if (out_valid !== 1'b1 || got !== 56'h0) begin fails++; $display("FAIL illegal_ones got v=%b %h exp 0", out_valid, got); end
`ifdef ALU_DEC_ILLEGAL_EN
        tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL illegal_flag got %b exp 1", illegal); end
        tests++; if (illegal_seen !== 1'b0) begin fails++; $display("FAIL illegal_seen_early got %b exp 0", illegal_seen); end
`endif
        send(32'h003110B3);
        tests++; if (got !== 56'h0) begin fails++; $display("FAIL illegal_sll got %h exp 0", got); end
        send(32'h023100B3);
        tests++; if (got !== 56'h0) begin fails++; $display("FAIL illegal_mul got %h exp 0", got); end
        send(32'h002081B3); e = mk(3'b000, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (got !== e) begin fails++; $display("FAIL after_illegal got %h exp %h", got, e); end
`ifdef ALU_DEC_ILLEGAL_EN
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL illegal_clear got %b exp 0", illegal); end
        tests++; if (illegal_seen !== 1'b1) begin fails++; $display("FAIL illegal_seen_sticky got %b exp 1", illegal_seen); end
`endif
        drain();
    endtask

    task automatic test_back_to_back();
        int acc;
        logic [55:0] e;
        acc = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_insn   = 32'h002081B3;
        for (int c = 0; c < 3; c++) begin
            if (in_ready === 1'b1) acc++;
            @(posedge clk); #1;
            if (acc == 1) in_insn = 32'h407302B3;
            if (acc == 2) in_insn = 32'hFFF00093;
        end
        tests++; if (acc != 2) begin fails++; $display("FAIL bp_accepts got %0d exp 2", acc); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        e = mk(3'b000, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b1 || got !== e) begin fails++; $display("FAIL bp_hold got v=%b %h exp %h", out_valid, got, e); end
        out_ready = 1'b1;
        tick();
        e = mk(3'b001, 1'b0, 32'h0, 5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b1 || got !== e) begin fails++; $display("FAIL bp_second got v=%b %h exp %h", out_valid, got, e); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        e = mk(3'b000, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (out_valid !== 1'b1 || got !== e) begin fails++; $display("FAIL bp_third got v=%b %h exp %h", out_valid, got, e); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        send(32'h002081B3);
        out_ready = 1'b0;
        in_insn   = 32'h407302B3;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_before_reset got %b exp 0", in_ready); end
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_full_out_valid got %b exp 0", out_valid); end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_full_in_ready got %b exp 1", in_ready); end
        tests++; if (out_valid !== 1'b0 || got !== 56'h0) begin fails++; $display("FAIL rst_full_stale got v=%b %h exp 0", out_valid, got); end
`ifdef ALU_DEC_ILLEGAL_EN
        tests++; if (illegal_seen !== 1'b0) begin fails++; $display("FAIL rst_illegal_seen got %b exp 0", illegal_seen); end
`endif
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_full_no_replay got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_mem();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_full();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
